// File: rtl/udp_tx_sched.sv
// -----------------------------------------------------------------------------
// udp_tx_sched
//
// Shares one UDP/RGMII transmit engine between two payload sources.
// A round-robin arbiter picks a requesting source, checks the requested
// payload length, starts the engine with the byte count, and steers the
// engine's payload read strobes and data to and from the granted source.
// After every frame, whether sent, rejected or aborted, an idle gap of
// GAP_CYC cycles is inserted. A watchdog aborts a frame when the engine
// does not report completion in time.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   req[1:0]      per-source frame request (level, held until done/err)
//   len0, len1    per-source payload byte count, stable while requesting
//   data0, data1  per-source payload word
//   rd_en[1:0]    per-source payload read strobe (engine tx_req, steered)
//   grant[1:0]    one-hot owner of the engine from START through SEND
//   done_pulse    1-cycle completion pulse, one bit per source
//   err           1-cycle reject (bad length) or abort (timeout) pulse
//   busy          high whenever the scheduler is not IDLE
//   tx_start      1-cycle start pulse to the engine
//   tx_byte_num   payload byte count presented to the engine
//   tx_req        engine asks for the next payload word
//   tx_data       payload word to the engine
//   tx_done       engine finished the current frame (1-cycle pulse)
// -----------------------------------------------------------------------------
module udp_tx_sched #(
  parameter int LEN_W   = 16,
  parameter int MAX_LEN = 1472,
  parameter int GAP_CYC = 12,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [31:0]      data0,
  input  logic [31:0]      data1,
  output logic [1:0]       rd_en,
  output logic [1:0]       grant,
  output logic [1:0]       done_pulse,
  output logic [1:0]       err,
  output logic             busy,
  output logic             tx_start,
  output logic [LEN_W-1:0] tx_byte_num,
  input  logic             tx_req,
  output logic [31:0]      tx_data,
  input  logic             tx_done
);

  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_SEND,
    S_GAP
  } state_t;

  state_t             state;
  logic               ptr;       // source favoured by the next arbitration
  logic               winner;    // source owning the current frame
  logic [WD_W-1:0]    wd_cnt;    // cycles elapsed since tx_start
  logic [GAP_W-1:0]   gap_cnt;

  logic               arb_win;
  logic [LEN_W-1:0]   arb_len;
  logic               len_bad;
  logic               in_send;

  function automatic logic [1:0] onehot(input logic src);
    return src ? 2'b10 : 2'b01;
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration: the pointer side wins if it is requesting, else the other.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a value first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    arb_win = ptr;
    if (!req[ptr]) begin
      arb_win = ~ptr;
    end
    arb_len = arb_win ? len1 : len0;
    len_bad = (arb_len == '0) || (arb_len > LEN_W'(MAX_LEN));
  end

  // ---------------------------------------------------------------------------
  // Payload steering is combinational so the engine sees data in the same
  // cycle it raises tx_req. Outside SEND nothing is strobed and source 0's
  // word is presented.
  // ---------------------------------------------------------------------------
  assign in_send = (state == S_SEND);
  assign rd_en   = in_send ? (grant & {2{tx_req}}) : 2'b00;
  assign tx_data = (in_send && grant[1]) ? data1 : data0;

  // ---------------------------------------------------------------------------
  // Scheduler FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before the clock edge, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= 1'b0;
      winner      <= 1'b0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      grant       <= 2'b00;
      done_pulse  <= 2'b00;
      err         <= 2'b00;
      busy        <= 1'b0;
      tx_start    <= 1'b0;
      tx_byte_num <= '0;
    end else begin
      // Pulse outputs default low; the branches below raise them for
      // exactly one cycle.
      tx_start   <= 1'b0;
      done_pulse <= 2'b00;
      err        <= 2'b00;

      unique case (state)
        S_IDLE: begin
          if (|req) begin
            state <= S_ARB;
            busy  <= 1'b1;
          end
        end

        S_ARB: begin
          if (req == 2'b00) begin
            // Request withdrawn before it could be served: nothing to do.
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            winner <= arb_win;
            ptr    <= ~arb_win;
            if (len_bad) begin
              err     <= onehot(arb_win);
              gap_cnt <= '0;
              state   <= S_GAP;
            end else begin
              tx_byte_num <= arb_len;
              grant       <= onehot(arb_win);
              tx_start    <= 1'b1;
              wd_cnt      <= '0;
              state       <= S_START;
            end
          end
        end

        S_START: begin
          // The watchdog counts from the tx_start cycle, so this cycle is 0.
          wd_cnt <= wd_cnt + WD_W'(1);
          state  <= S_SEND;
        end

        S_SEND: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (tx_done) begin
            done_pulse <= onehot(winner);
            grant      <= 2'b00;
            gap_cnt    <= '0;
            state      <= S_GAP;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            err     <= onehot(winner);
            grant   <= 2'b00;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_udp_tx_sched
//
// Directed bench for udp_tx_sched. Inputs are driven 1 ns after the rising
// edge and outputs are checked there as well, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_udp_tx_sched;

  localparam int LEN_W   = 16;
  localparam int MAX_LEN = 1472;
  localparam int GAP_CYC = 12;
  localparam int TIMEOUT = 4096;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [31:0]      data0;
  logic [31:0]      data1;
  logic [1:0]       rd_en;
  logic [1:0]       grant;
  logic [1:0]       done_pulse;
  logic [1:0]       err;
  logic             busy;
  logic             tx_start;
  logic [LEN_W-1:0] tx_byte_num;
  logic             tx_req;
  logic [31:0]      tx_data;
  logic             tx_done;

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (tx_start === 1'b1) start_cnt++;

  udp_tx_sched #(
    .LEN_W  (LEN_W),
    .MAX_LEN(MAX_LEN),
    .GAP_CYC(GAP_CYC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .len0       (len0),
    .len1       (len1),
    .data0      (data0),
    .data1      (data1),
    .rd_en      (rd_en),
    .grant      (grant),
    .done_pulse (done_pulse),
    .err        (err),
    .busy       (busy),
    .tx_start   (tx_start),
    .tx_byte_num(tx_byte_num),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_done    (tx_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 200 && tx_start !== 1'b1; i++) step();
    check({tag, "_start"}, tx_start, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy !== 1'b0; i++) step();
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // Waits for the next start, checks the grant and byte count, then lets the
  // engine finish two cycles into SEND and checks the completion pulse.
  task automatic run_frame(input string tag, input logic [1:0] exp_grant,
                           input logic [LEN_W-1:0] exp_len);
    wait_start(tag);
    check({tag, "_grant"}, grant, exp_grant);
    check({tag, "_len"}, tx_byte_num, exp_len);
    step(2);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check({tag, "_done"}, done_pulse, exp_grant);
    check({tag, "_noerr"}, err, 2'b00);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int s0;
    int c0;
    int c1;
    int cnt;

    rst_n   = 1'b0;
    req     = 2'b00;
    len0    = '0;
    len1    = '0;
    data0   = 32'h1111_0000;
    data1   = 32'h2222_0000;
    tx_req  = 1'b0;
    tx_done = 1'b0;
    step(3);

    // Reset state
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_start", tx_start, 1'b0);
    check("rst_bytes", tx_byte_num, 0);
    check("rst_rd_en", rd_en, 2'b00);
    check("rst_done", done_pulse, 2'b00);
    check("rst_err", err, 2'b00);
    rst_n = 1'b1;
    step();

    // 1: single frame from source 0, start latency and inter-frame gap
    len0 = 64;
    req  = 2'b01;
    step();
    check("t1_arb_busy", busy, 1'b1);
    check("t1_arb_nostart", tx_start, 1'b0);
    step();
    check("t1_start", tx_start, 1'b1);
    check("t1_grant", grant, 2'b01);
    check("t1_len", tx_byte_num, 64);
    step();
    check("t1_start_pulse_end", tx_start, 1'b0);
    step(2);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("t1_done", done_pulse, 2'b01);
    check("t1_grant_clr", grant, 2'b00);
    step();
    check("t1_done_1cyc", done_pulse, 2'b00);
    cnt = 1;
    while (tx_start !== 1'b1 && cnt < 60) begin
      step();
      cnt++;
    end
    // done_pulse follows tx_done by one cycle, so GAP_CYC+2 here is
    // GAP_CYC+3 cycles from tx_done to the next tx_start.
    check("t1_gap_to_start", cnt, GAP_CYC + 2);
    check("t1_len2", tx_byte_num, 64);
    step(2);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    req = 2'b00;
    check("t1_done2", done_pulse, 2'b01);
    wait_idle("t1");

    // 2: both sources requesting alternate, starting from source 0
    do_reset();
    len0 = 100;
    len1 = 100;
    req  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("t2_f%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, 100);
    end
    req = 2'b00;
    wait_idle("t2");

    // 3: illegal lengths are rejected without starting the engine;
    //    MAX_LEN itself is accepted
    s0 = start_cnt;
    len0 = 0;
    req  = 2'b01;
    step(2);
    check("t3_len0_err", err, 2'b01);
    check("t3_len0_grant", grant, 2'b00);
    req = 2'b00;
    step();
    check("t3_err_1cyc", err, 2'b00);
    wait_idle("t3a");
    len0 = 1500;
    req  = 2'b01;
    step(2);
    check("t3_len1500_err", err, 2'b01);
    req = 2'b00;
    wait_idle("t3b");
    len0 = MAX_LEN + 1;
    req  = 2'b01;
    step(2);
    check("t3_len1473_err", err, 2'b01);
    req = 2'b00;
    wait_idle("t3c");
    check("t3_no_start", start_cnt - s0, 0);
    len0 = MAX_LEN;
    req  = 2'b01;
    run_frame("t3_max", 2'b01, MAX_LEN);
    req = 2'b00;
    wait_idle("t3d");

    // 4: payload steering for source 1
    len1 = 200;
    req  = 2'b10;
    wait_start("t4");
    check("t4_grant", grant, 2'b10);
    tx_req = 1'b1;
    #1;
    check("t4_start_rd_en", rd_en, 2'b00);
    check("t4_start_data", tx_data, 32'h1111_0000);
    step();
    for (int k = 0; k < 4; k++) begin
      data1 = 32'hA5A5_0001 + k;
      #1;
      check($sformatf("t4_rd_en%0d", k), rd_en, 2'b10);
      check($sformatf("t4_data%0d", k), tx_data, 32'hA5A5_0001 + k);
      step();
    end
    tx_req = 1'b0;
    #1;
    check("t4_rd_en_off", rd_en, 2'b00);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    req = 2'b00;
    check("t4_done", done_pulse, 2'b10);
    tx_done = 1'b1;
    tx_req  = 1'b1;
    #1;
    check("t4_gap_rd_en", rd_en, 2'b00);
    step();
    tx_done = 1'b0;
    tx_req  = 1'b0;
    check("t4_gap_done_ignored", done_pulse, 2'b00);
    wait_idle("t4");

    // 5: watchdog abort, then completion on the expiry cycle wins
    len0 = 10;
    req  = 2'b01;
    wait_start("t5");
    c0 = cyc;
    for (int i = 0; i < TIMEOUT + 20 && err === 2'b00; i++) step();
    c1 = cyc;
    check("t5_err", err, 2'b01);
    check("t5_no_done", done_pulse, 2'b00);
    check("t5_grant_clr", grant, 2'b00);
    check("t5_err_latency", c1 - c0, TIMEOUT);
    req = 2'b00;
    cnt = 0;
    while (busy !== 1'b0 && cnt < 100) begin
      step();
      cnt++;
    end
    check("t5_gap_len", cnt, GAP_CYC);
    req = 2'b01;
    wait_start("t5b");
    step(TIMEOUT - 1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("t5_tie_done", done_pulse, 2'b01);
    check("t5_tie_noerr", err, 2'b00);
    req = 2'b00;
    wait_idle("t5");

    // 6: asynchronous reset during SEND, then pointer restarts at source 0
    len0 = 50;
    req  = 2'b01;
    wait_start("t6");
    step(2);
    tx_req = 1'b1;
    #1;
    check("t6_pre_rd_en", rd_en, 2'b01);
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", grant, 2'b00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_rd_en", rd_en, 2'b00);
    check("t6_rst_start", tx_start, 1'b0);
    check("t6_rst_bytes", tx_byte_num, 0);
    check("t6_rst_done", done_pulse, 2'b00);
    check("t6_rst_err", err, 2'b00);
    check("t6_rst_data", tx_data, 32'h1111_0000);
    tx_req = 1'b0;
    req    = 2'b00;
    step();
    rst_n = 1'b1;
    step(2);
    check("t6_post_done", done_pulse, 2'b00);
    check("t6_post_err", err, 2'b00);
    check("t6_post_busy", busy, 1'b0);
    len1 = 60;
    req  = 2'b11;
    run_frame("t6_after", 2'b01, 50);
    req = 2'b00;
    wait_idle("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
